// File: rtl/ct_accum.sv
// Slot-wise modular accumulator for ciphertext terms: sums (A,B) pairs mod Q over a
// stream of terms ending at in_last, then holds the result until the consumer takes it.
module ct_accum #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned Q     = 17,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0][N-1:0][W-1:0]     in_ct,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0][N-1:0][W-1:0]     out_ct,
  output logic [CNT_W-1:0]             out_count
);

  // in_ct[0] / out_ct[0] carry the A polynomial, index 1 carries B.
  typedef logic [1:0][N-1:0][W-1:0] ct_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [W-1:0] QN = W'(Q);
  localparam logic [W:0]   QS = {1'b0, QN};

  state_e           state_q, state_d;
  ct_t              acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  function automatic logic [W-1:0] red_w(input logic [W-1:0] x);
    return (x >= QN) ? (x - QN) : x;
  endfunction

  // Sum kept at W+1 bits so a+b never truncates before the conditional subtract.
  function automatic logic [W-1:0] addq_w(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QS) s = s - QS;
    return s[W-1:0];
  endfunction

  function automatic ct_t red_ct(input ct_t x);
    ct_t r;
    for (int unsigned h = 0; h < 2; h++)
      for (int unsigned i = 0; i < N; i++)
        r[h][i] = red_w(x[h][i]);
    return r;
  endfunction

  function automatic ct_t addq_ct(input ct_t a, input ct_t b);
    ct_t r;
    for (int unsigned h = 0; h < 2; h++)
      for (int unsigned i = 0; i < N; i++)
        r[h][i] = addq_w(a[h][i], b[h][i]);
    return r;
  endfunction

  assign in_ready  = (state_q != S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign out_ct    = acc_q;
  assign out_count = cnt_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = red_ct(in_ct);
          cnt_d   = CNT_W'(1);
          state_d = in_last ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d   = addq_ct(acc_q, red_ct(in_ct));
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ct_accum.sv
// Bench for ct_accum: directed corner cases plus random term streams checked against
// an integer-arithmetic model of the slot-wise mod-Q sum.
module tb_ct_accum;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned Q     = 17;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  typedef logic [1:0][N-1:0][W-1:0] ct_t;
  typedef struct { ct_t ct; bit last; } term_t;
  typedef struct { ct_t ct; int unsigned cnt; } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  ct_t              in_ct = '0;
  logic             in_ready;
  logic             out_valid;
  ct_t              out_ct;
  logic [CNT_W-1:0] out_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ct_accum #(.N(N), .W(W), .Q(Q), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ct_t garbage();
    ct_t c;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < N; i++)
        c[h][i] = W'($urandom_range(0, 255));
    return c;
  endfunction

  function automatic ct_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3);
    ct_t c;
    c[0][0] = W'(a0); c[0][1] = W'(a1); c[0][2] = W'(a2); c[0][3] = W'(a3);
    c[1][0] = W'(b0); c[1][1] = W'(b1); c[1][2] = W'(b2); c[1][3] = W'(b3);
    return c;
  endfunction

  // Present one term, wait (bounded) for acceptance; returns at edge+1 of the accepting edge.
  task automatic put(input ct_t c, input bit last);
    bit seen;
    seen = 1'b0;
    in_valid = 1'b1;
    in_ct    = c;
    in_last  = last;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    check("put_accepted", 64'(seen), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_ct    = garbage();
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  term_t terms[$];
  res_t  exp_q[$];
  res_t  e;
  ct_t   held, x;
  int    sum[2][N];
  int unsigned k, v, idx, got, nres, cycles;

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_ct", 64'(out_ct), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);

    // Single-term sum
    put(mk(3, 16, 0, 5, 1, 2, 3, 4), 1'b1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_ct", 64'(out_ct), 64'(mk(3, 16, 0, 5, 1, 2, 3, 4)));
    check("single_cnt", 64'(out_count), 64'd1);
    check("single_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drained", 64'(out_valid), 64'd0);
    check("single_cleared", 64'(out_ct), 64'd0);

    // Three back-to-back terms, consumer always ready
    out_ready = 1'b1;
    put(mk(10, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    put(mk(12, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    put(mk(15, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_a0", 64'(out_ct[0][0]), 64'd3);
    check("b2b_cnt", 64'(out_count), 64'd3);
    tick();
    check("b2b_one_cycle", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Non-canonical input and modular boundaries
    put(mk(0, 20, 0, 0, 0, 0, 0, 0), 1'b1);
    check("noncanon_a1", 64'(out_ct[0][1]), 64'd3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    put(mk(16, 16, 0, 0, 33, 0, 0, 0), 1'b0);
    put(mk(16, 1, 0, 0, 33, 0, 0, 0), 1'b1);
    check("bound_16p16", 64'(out_ct[0][0]), 64'd15);
    check("bound_16p1", 64'(out_ct[0][1]), 64'd0);
    check("bound_33p33", 64'(out_ct[1][0]), 64'd15);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure in DONE with upstream holding a term
    put(mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1);
    held = out_ct;
    x = mk(9, 30, 11, 12, 13, 14, 15, 33);
    in_valid = 1'b1; in_ct = x; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_ct_stable", 64'(out_ct), 64'(held));
      check("bp_cnt_stable", 64'(out_count), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", 64'(out_valid), 64'd0);
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_ct", 64'(out_ct), 64'(mk(9, 13, 11, 12, 13, 14, 15, 16)));
    check("bp_next_cnt", 64'(out_count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset in ACC, with a simultaneous handshake attempt
    put(mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    put(mk(6, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_ct = mk(8, 0, 0, 0, 0, 0, 0, 0); in_last = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rstacc_valid", 64'(out_valid), 64'd0);
    check("rstacc_ct", 64'(out_ct), 64'd0);
    check("rstacc_cnt", 64'(out_count), 64'd0);
    put(mk(7, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    check("rstacc_next_ct", 64'(out_ct), 64'(mk(7, 0, 0, 0, 0, 0, 0, 0)));
    check("rstacc_next_cnt", 64'(out_count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Counter saturation: 17 terms of A[0]=1
    for (int i = 0; i < 17; i++) put(mk(1, 0, 0, 0, 0, 0, 0, 0), i == 16);
    check("sat_cnt", 64'(out_count), 64'(CMAX));
    check("sat_a0", 64'(out_ct[0][0]), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Random streams with stalls on both sides
    nres = 40;
    for (int s = 0; s < int'(nres); s++) begin
      k = $urandom_range(1, 20);
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < N; i++) sum[h][i] = 0;
      for (int t = 0; t < int'(k); t++) begin
        term_t tt;
        for (int h = 0; h < 2; h++)
          for (int i = 0; i < N; i++) begin
            v = $urandom_range(0, 2 * Q - 1);
            tt.ct[h][i] = W'(v);
            sum[h][i] += int'(v);
          end
        tt.last = (t == int'(k) - 1);
        terms.push_back(tt);
      end
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < N; i++) e.ct[h][i] = W'(sum[h][i] % Q);
      e.cnt = (k > CMAX) ? CMAX : k;
      exp_q.push_back(e);
    end
    idx = 0; got = 0; cycles = 0;
    while (got < nres && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      if (idx < terms.size() && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_ct = terms[idx].ct; in_last = terms[idx].last;
      end else begin
        in_valid = 1'b0; in_ct = garbage(); in_last = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_result", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_ct", 64'(out_ct), 64'(e.ct));
          check("rand_cnt", 64'(out_count), 64'(e.cnt));
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_all_results", 64'(got), 64'(nres));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ct_accum.md
CT_ACCUM -- requirements
Module: ct_accum

Interface
REQ-001 Parameter N, default N_SLOTS_L: number of slots per polynomial.
REQ-002 Parameter W, default W_BITS_L: bits per slot word.
REQ-003 Parameter Q, default Q_MOD_L: ciphertext modulus q; SHALL satisfy 2 <= Q < 2^W.
REQ-004 Parameter CNT_W, default 16: width of the term counter.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 in_valid  input  1: in_ct/in_last are valid this cycle.
REQ-008 in_ready  output  1: block accepts a term this cycle.
REQ-009 in_ct  input  CT_t: one term (A,B), normally the output of the ct-pt multiply stage.
REQ-010 in_last  input  1: the accepted term is the final term of the current sum.
REQ-011 out_valid  output  1: out_ct/out_count hold a completed sum.
REQ-012 out_ready  input  1: consumer accepts the result.
REQ-013 out_ct  output  CT_t: completed sum (ΣA, ΣB) mod q, slot-wise.
REQ-014 out_count  output  CNT_W: number of terms in the completed sum.

Function
REQ-015 The block SHALL compute out_ct.A[i] = (Σ_k in_ct_k.A[i]) mod Q and the same for B, for all i in 0..N-1, over the terms accepted from the first term through the in_last term.
REQ-016 Term acceptance SHALL occur exactly on cycles where in_valid && in_ready; result delivery SHALL occur exactly on cycles where out_valid && out_ready.
REQ-017 The states SHALL be IDLE (no partial sum), ACC (partial sum held) and DONE (result held).
REQ-018 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-019 IDLE, accept with in_last=0: acc <= red(in_ct), count <= 1, next state ACC.
REQ-020 IDLE, accept with in_last=1: acc <= red(in_ct), count <= 1, next state DONE (single-term sum).
REQ-021 ACC, accept: acc <= acc +q red(in_ct), count <= count+1; next state DONE if in_last, else ACC.
REQ-022 DONE, out_ready=1: next state IDLE, acc and count cleared to 0; out_ready=0: hold all outputs stable.
REQ-023 Latency: a term accepted with in_last at edge t SHALL give out_valid=1 with the final sum in the cycle after edge t; sustained throughput SHALL be one term per cycle while not in DONE.
REQ-024 red(x) SHALL be x-Q if x >= Q, else x, per word; inputs SHALL be correct for words < 2Q.
REQ-025 Modular add +q SHALL use a W+1-bit sum s = a+b, then return s-Q if s >= Q, else s; no intermediate truncation to W bits.
REQ-026 out_ct SHALL present the acc register directly (registered output, no combinational path from in_ct).
REQ-027 count SHALL saturate at 2^CNT_W-1 and not wrap; the accumulated value SHALL remain correct beyond saturation.
REQ-028 in_valid in DONE SHALL be ignored (no acceptance, no state change); the upstream holds its term.
REQ-029 Outputs SHALL be insensitive to in_ct/in_last on cycles without acceptance.

Reset
REQ-030 While rst=1 at a rising edge: state <= IDLE, acc (all A,B slots) <= 0, count <= 0.
REQ-031 During and after reset: out_valid=0, out_ct all zeros, out_count=0, in_ready=1 from the first cycle after reset deasserts.
REQ-032 Reset asserted in ACC or DONE SHALL discard the partial or held sum; no result SHALL be emitted for it.
REQ-033 rst SHALL take priority over simultaneous input acceptance or output handshake.

Verification (bench: N=4, W=8, Q=17)
REQ-034 Single term A=[3,16,0,5], B=[1,2,3,4], in_last=1 -> next cycle out_valid=1, out_ct equals input, out_count=1.
REQ-035 Three back-to-back terms A[0]=10,12,15 (last on third), out_ready=1 -> out_ct.A[0]=(37 mod 17)=3, out_count=3, out_valid asserted exactly one cycle.
REQ-036 Non-canonical input A[1]=20 (<2Q) in a single term -> out_ct.A[1]=3; boundary sum 16+16 -> 15; 16+1 -> 0.
REQ-037 DONE with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_ct/out_count stable, term accepted only after out_ready=1 handshake.
REQ-038 rst asserted after two terms (in ACC) -> out_valid stays 0; next single-term sum A[0]=7 yields out_ct.A[0]=7, out_count=1.
REQ-039 Random streams of 1..20 terms against a reference model of the slot-wise mod-Q sum, with random in_valid/out_ready stalls -> every result and count match.
